// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/execute control FSM for the simple CPU.
module cpu_control_sequencer #(
  parameter int OPC_MSB = 22,
  parameter int RX_LSB  = 16,
  parameter int RY_LSB  = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [22:0] instr,
  input  logic        zflag,
  output logic [4:0]  state,
  output logic        ir_load,
  output logic [3:0]  tribuf,
  output logic [3:0]  r_en,
  output logic        r_we,
  output logic        alu_sub,
  output logic        branch,
  output logic        PC_step,
  output logic        done,
  output logic        halted
);
  typedef enum logic [4:0] {
    IDLE   = 5'b00000,
    LOAD   = 5'b00001,
    MOV    = 5'b00010,
    AR_T1  = 5'b00011,
    AR_T2  = 5'b00100,
    AR_T3  = 5'b00101,
    FETCH  = 5'b01000,
    DECODE = 5'b01010,
    BR     = 5'b01100,
    HALT   = 5'b11111
  } state_t;
  state_t cur, nxt;
  logic [2:0] opc;
  logic [3:0] rx, ry;
  logic taken, retire, unused;
  assign opc = instr[OPC_MSB -: 3];
  assign rx = instr[RX_LSB +: 4];
  assign ry = instr[RY_LSB +: 4];
  assign unused = ^instr;
  assign taken = opc == 3'b100 || (opc == 3'b101 && zflag);
  assign state = cur;
  assign done = retire;
  assign PC_step = retire & ~branch;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    ir_load = 1'b0;
    tribuf = 4'd0;
    r_en = 4'd0;
    r_we = 1'b0;
    alu_sub = 1'b0;
    branch = 1'b0;
    retire = 1'b0;
    halted = 1'b0;
    case (cur)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: begin
        ir_load = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        nxt = opc == 3'b000 ? LOAD : opc == 3'b001 ? MOV :
              opc[2:1] == 2'b01 ? AR_T1 : opc[2:1] == 2'b10 ? BR : HALT;
        retire = opc == 3'b110;
      end
      LOAD: begin tribuf = 4'd10; r_en = rx; r_we = 1'b1; retire = 1'b1; end
      MOV: begin tribuf = ry; r_en = rx; r_we = 1'b1; retire = 1'b1; end
      AR_T1: begin tribuf = rx; r_en = 4'd10; r_we = 1'b1; nxt = AR_T2; end
      AR_T2: begin tribuf = ry; r_en = 4'd9; r_we = 1'b1; alu_sub = opc[0]; nxt = AR_T3; end
      AR_T3: begin tribuf = 4'd9; r_en = rx; r_we = 1'b1; retire = 1'b1; end
      BR: begin tribuf = rx; branch = taken; retire = 1'b1; end
      HALT: halted = 1'b1;
      default: nxt = IDLE;
    endcase
    // run is only looked at when an instruction retires (or in IDLE)
    if (retire) nxt = run ? FETCH : IDLE;
  end
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: randomized self-checking bench against a per-opcode cycle-table model.
module tb_cpu_control_sequencer;
  localparam logic [4:0] S_IDLE = 5'b00000, S_LOAD = 5'b00001, S_MOV = 5'b00010,
    S_T1 = 5'b00011, S_T2 = 5'b00100, S_T3 = 5'b00101, S_FETCH = 5'b01000,
    S_DEC = 5'b01010, S_BR = 5'b01100, S_HALT = 5'b11111;
  logic clk, resetn, run, mem_ready, zflag;
  logic [22:0] instr;
  logic [4:0] state;
  logic [3:0] tribuf, r_en;
  logic ir_load, r_we, alu_sub, branch, PC_step, done, halted;
  int n_cmp = 0, n_bad = 0;
  cpu_control_sequencer dut (
    .clk(clk), .resetn(resetn), .run(run), .mem_ready(mem_ready), .instr(instr),
    .zflag(zflag), .state(state), .ir_load(ir_load), .tribuf(tribuf), .r_en(r_en),
    .r_we(r_we), .alu_sub(alu_sub), .branch(branch), .PC_step(PC_step), .done(done),
    .halted(halted)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [19:0] v(input logic [4:0] s, input logic ir, input logic [3:0] tb,
      input logic [3:0] en, input logic we, input logic sub, input logic br, input logic ps,
      input logic dn, input logic h);
    return {s, ir, tb, en, we, sub, br, ps, dn, h};
  endfunction
  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [19:0] obs();
    return {state, ir_load, tribuf, r_en, r_we, alu_sub, branch, PC_step, done, halted};
  endfunction
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1 chk(tag, obs(), exp);
    @(negedge clk);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    run = 1'b0;
    #1 chk("reset", obs(), v(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetn = 1'b1;
    run = 1'b1;
    cyc("idle_go", v(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  // Starts and ends at a negedge with the FSM in FETCH; fin is run during the retire cycle.
  task automatic exec(input logic [2:0] opc, input logic [3:0] rx, input logic [3:0] ry,
      input logic zf, input int waits, input logic fin, input int rst_at);
    logic [19:0] e[$];
    logic tk;
    instr = {opc, rx, ry, 12'($urandom)};
    zflag = zf;
    tk = opc == 3'b100 || (opc == 3'b101 && zf);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      run = 1'($urandom);
      cyc("fetch_wait", v(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    mem_ready = 1'b1;
    run = 1'($urandom);
    cyc("fetch", v(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'($urandom);
    e.push_back(opc == 3'b110 ? v(S_DEC, 0, 0, 0, 0, 0, 0, 1, 1, 0) : v(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (opc)
      3'b000: e.push_back(v(S_LOAD, 0, 10, rx, 1, 0, 0, 1, 1, 0));
      3'b001: e.push_back(v(S_MOV, 0, ry, rx, 1, 0, 0, 1, 1, 0));
      3'b010, 3'b011: begin
        e.push_back(v(S_T1, 0, rx, 10, 1, 0, 0, 0, 0, 0));
        e.push_back(v(S_T2, 0, ry, 9, 1, opc[0], 0, 0, 0, 0));
        e.push_back(v(S_T3, 0, 9, rx, 1, 0, 0, 1, 1, 0));
      end
      3'b100, 3'b101: e.push_back(v(S_BR, 0, rx, 0, 0, 0, tk, !tk, 1, 0));
      3'b111: repeat (4) e.push_back(v(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      default: ;
    endcase
    for (int i = 0; i < e.size(); i++) begin
      run = (i == e.size() - 1 && opc != 3'b111) ? fin : 1'($urandom);
      if (i == rst_at) begin
        #1 chk("pre_reset", obs(), e[i]);
        resetn = 1'b0;
        #1 chk("async_reset", obs(), v(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        do_reset();
        return;
      end
      cyc($sformatf("op%0d_c%0d", opc, i), e[i]);
    end
    if (opc == 3'b111) begin
      do_reset();
    end else if (!fin) begin
      repeat ($urandom_range(1, 2)) begin
        run = 1'b0;
        cyc("idle_hold", v(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      run = 1'b1;
      cyc("idle_resume", v(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask
  initial begin
    resetn = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    zflag = 1'b0;
    instr = '0;
    @(negedge clk);
    do_reset();
    exec(3'b000, 4'd3, 4'd0, 0, 0, 1, -1);
    exec(3'b011, 4'd2, 4'd5, 0, 0, 1, -1);
    exec(3'b101, 4'd4, 4'd1, 1, 0, 1, -1);
    exec(3'b101, 4'd4, 4'd1, 0, 0, 1, -1);
    exec(3'b001, 4'd7, 4'd8, 0, 3, 1, -1);
    exec(3'b100, 4'd6, 4'd0, 0, 0, 1, -1);
    exec(3'b110, 4'd0, 4'd0, 0, 0, 1, -1);
    exec(3'b010, 4'd1, 4'd6, 0, 0, 0, -1);
    exec(3'b010, 4'd1, 4'd6, 0, 1, 1, 2);
    exec(3'b111, 4'd0, 4'd0, 0, 0, 1, -1);
    repeat (300)
      exec(3'($urandom), 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)), 1'($urandom),
           $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
